// File: rtl/mem_cycle_sequencer_pkg.sv
// Shared types for the core memory cycle sequencer.
// Cycle states, requester codes and counter widths.
package mem_cycle_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SELECT  = 3'd1,
        S_READ    = 3'd2,
        S_STROBE  = 3'd3,
        S_WRITE   = 3'd4,
        S_RECOVER = 3'd5
    } state_e;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_e;

    localparam int unsigned PHASE_W = 4;
    localparam int unsigned BURST_W = 4;

endpackage

// File: rtl/mem_req_arbiter.sv
// Two-way CPU/DMA arbiter; DMA is favoured until its burst
// allowance is used up while the CPU is waiting.
module mem_req_arbiter
    import mem_cycle_sequencer_pkg::*;
#(
    parameter int unsigned DMA_BURST_MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic cpu_req,
    input  logic dma_req,
    output logic grant_cpu,
    output logic grant_dma
);

    logic [BURST_W-1:0] burst;
    logic               burst_full;
    logic               cpu_turn;

    assign burst_full = (burst == BURST_W'(DMA_BURST_MAX));
    assign cpu_turn   = cpu_req && burst_full;
    assign grant_dma  = en && dma_req && !cpu_turn;
    assign grant_cpu  = en && cpu_req && !grant_dma;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst <= '0;
        end else if (grant_cpu) begin
            burst <= '0;
        end else if (grant_dma && !burst_full) begin
            burst <= burst + BURST_W'(1);
        end
    end

endmodule

// File: rtl/mem_cycle_sequencer.sv
// Core memory access sequencer: select, destructive read, sense
// strobe and inhibit/restore write, shared between CPU and DMA.
module mem_cycle_sequencer
    import mem_cycle_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_W        = 13,
    parameter int unsigned DATA_W        = 28,
    parameter int unsigned RD_CYCLES     = 3,
    parameter int unsigned WR_CYCLES     = 3,
    parameter int unsigned DMA_BURST_MAX = 4
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              CPU_REQ,
    input  logic              CPU_WE,
    input  logic [ADDR_W-1:0] CPU_ADDR,
    input  logic [DATA_W-1:0] CPU_WDATA,
    output logic              CPU_ACK,
    output logic [DATA_W-1:0] CPU_RDATA,
    input  logic              DMA_REQ,
    input  logic              DMA_WE,
    input  logic [ADDR_W-1:0] DMA_ADDR,
    input  logic [DATA_W-1:0] DMA_WDATA,
    output logic              DMA_ACK,
    output logic [DATA_W-1:0] DMA_RDATA,
    input  logic              DUPLEX,
    input  logic              MODSEL,
    output logic              MAO,
    output logic              MBO,
    output logic              RD,
    output logic              SYNC,
    output logic              INHBS,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_INH,
    input  logic [DATA_W-1:0] MEM_RDATA_A,
    input  logic [DATA_W-1:0] MEM_RDATA_B,
    output logic              MISCMP,
    output logic              BUSY
);

    state_e              state;
    state_e              state_nx;
    logic [PHASE_W-1:0]  phase;
    logic [PHASE_W-1:0]  phase_nx;
    owner_e              owner;
    logic                we_q;
    logic                duplex_q;
    logic                modsel_q;
    logic                mis_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   cap_q;
    logic [DATA_W-1:0]   sense;
    logic [DATA_W-1:0]   restore;
    logic                grant_cpu;
    logic                grant_dma;
    logic                grant;
    logic                use_a;
    logic                use_b;
    logic                ack;

    mem_req_arbiter #(
        .DMA_BURST_MAX(DMA_BURST_MAX)
    ) u_arb (
        .clk      (CLK),
        .rst_n    (RSTN),
        .en       (state == S_IDLE),
        .cpu_req  (CPU_REQ),
        .dma_req  (DMA_REQ),
        .grant_cpu(grant_cpu),
        .grant_dma(grant_dma)
    );

    assign grant = grant_cpu | grant_dma;
    assign use_a = duplex_q | ~modsel_q;
    assign use_b = duplex_q | modsel_q;

    always_comb begin
        state_nx = state;
        phase_nx = phase;
        unique case (state)
            S_IDLE: begin
                if (grant) state_nx = S_SELECT;
            end
            S_SELECT: begin
                state_nx = S_READ;
                phase_nx = '0;
            end
            S_READ: begin
                if (phase == PHASE_W'(RD_CYCLES - 1)) begin
                    state_nx = S_STROBE;
                    phase_nx = '0;
                end else begin
                    phase_nx = phase + PHASE_W'(1);
                end
            end
            S_STROBE: begin
                state_nx = S_WRITE;
                phase_nx = '0;
            end
            S_WRITE: begin
                if (phase == PHASE_W'(WR_CYCLES - 1)) begin
                    state_nx = S_RECOVER;
                    phase_nx = '0;
                end else begin
                    phase_nx = phase + PHASE_W'(1);
                end
            end
            S_RECOVER: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
                phase_nx = '0;
            end
        endcase
    end

    // Duplex always reads through module A; B only feeds the compare.
    assign sense = use_a ? MEM_RDATA_A : MEM_RDATA_B;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state    <= S_IDLE;
            phase    <= '0;
            owner    <= OWN_CPU;
            we_q     <= 1'b0;
            duplex_q <= 1'b0;
            modsel_q <= 1'b0;
            mis_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cap_q    <= '0;
        end else begin
            state <= state_nx;
            phase <= phase_nx;
            if (grant) begin
                owner    <= grant_dma ? OWN_DMA : OWN_CPU;
                we_q     <= grant_dma ? DMA_WE : CPU_WE;
                addr_q   <= grant_dma ? DMA_ADDR : CPU_ADDR;
                wdata_q  <= grant_dma ? DMA_WDATA : CPU_WDATA;
                duplex_q <= DUPLEX;
                modsel_q <= MODSEL;
                mis_q    <= 1'b0;
            end
            if (state == S_STROBE) begin
                cap_q <= sense;
                mis_q <= duplex_q && (MEM_RDATA_A != MEM_RDATA_B);
            end
        end
    end

    assign restore   = we_q ? wdata_q : cap_q;
    assign ack       = (state == S_RECOVER);
    assign BUSY      = (state != S_IDLE);
    assign MAO       = BUSY && use_a;
    assign MBO       = BUSY && use_b;
    assign RD        = (state == S_READ);
    assign SYNC      = (state == S_STROBE);
    assign INHBS     = (state == S_WRITE);
    assign MEM_ADDR  = addr_q;
    assign MEM_INH   = INHBS ? ~restore : '0;
    assign CPU_ACK   = ack && (owner == OWN_CPU);
    assign DMA_ACK   = ack && (owner == OWN_DMA);
    assign CPU_RDATA = CPU_ACK ? cap_q : '0;
    assign DMA_RDATA = DMA_ACK ? cap_q : '0;
    assign MISCMP    = ack && mis_q;

endmodule

// File: tb/tb_mem_cycle_sequencer.sv
// Scoreboard bench for mem_cycle_sequencer with a behavioural
// two-module core memory and a word-level reference model.
module tb_mem_cycle_sequencer;

    localparam int AW = 13;
    localparam int DW = 28;

    logic          CLK = 1'b0;
    logic          RSTN = 1'b0;
    logic          CPU_REQ = 1'b0;
    logic          CPU_WE = 1'b0;
    logic [AW-1:0] CPU_ADDR = '0;
    logic [DW-1:0] CPU_WDATA = '0;
    logic          CPU_ACK;
    logic [DW-1:0] CPU_RDATA;
    logic          DMA_REQ = 1'b0;
    logic          DMA_WE = 1'b0;
    logic [AW-1:0] DMA_ADDR = '0;
    logic [DW-1:0] DMA_WDATA = '0;
    logic          DMA_ACK;
    logic [DW-1:0] DMA_RDATA;
    logic          DUPLEX = 1'b0;
    logic          MODSEL = 1'b0;
    logic          MAO, MBO, RD, SYNC, INHBS, MISCMP, BUSY;
    logic [AW-1:0] MEM_ADDR;
    logic [DW-1:0] MEM_INH;
    logic [DW-1:0] MEM_RDATA_A;
    logic [DW-1:0] MEM_RDATA_B;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [DW-1:0] rdata;
        logic          mis;
    } exp_t;

    exp_t cpu_q[$];
    exp_t dma_q[$];
    bit   ack_log[$];

    logic [DW-1:0] mem_a [2**AW];
    logic [DW-1:0] mem_b [2**AW];
    logic [DW-1:0] ref_a [2**AW];
    logic [DW-1:0] ref_b [2**AW];
    logic [DW-1:0] pend_word;
    logic [AW-1:0] pend_addr;
    logic          pend_a;
    logic          pend_b;

    always #5 CLK = ~CLK;

    mem_cycle_sequencer dut (
        .CLK        (CLK),
        .RSTN       (RSTN),
        .CPU_REQ    (CPU_REQ),
        .CPU_WE     (CPU_WE),
        .CPU_ADDR   (CPU_ADDR),
        .CPU_WDATA  (CPU_WDATA),
        .CPU_ACK    (CPU_ACK),
        .CPU_RDATA  (CPU_RDATA),
        .DMA_REQ    (DMA_REQ),
        .DMA_WE     (DMA_WE),
        .DMA_ADDR   (DMA_ADDR),
        .DMA_WDATA  (DMA_WDATA),
        .DMA_ACK    (DMA_ACK),
        .DMA_RDATA  (DMA_RDATA),
        .DUPLEX     (DUPLEX),
        .MODSEL     (MODSEL),
        .MAO        (MAO),
        .MBO        (MBO),
        .RD         (RD),
        .SYNC       (SYNC),
        .INHBS      (INHBS),
        .MEM_ADDR   (MEM_ADDR),
        .MEM_INH    (MEM_INH),
        .MEM_RDATA_A(MEM_RDATA_A),
        .MEM_RDATA_B(MEM_RDATA_B),
        .MISCMP     (MISCMP),
        .BUSY       (BUSY)
    );

    assign MEM_RDATA_A = mem_a[MEM_ADDR];
    assign MEM_RDATA_B = mem_b[MEM_ADDR];

    function automatic logic [DW-1:0] init_word(input int i);
        if (i == 32'h123) return 28'h0ABCDEF;
        return 28'((i * 32'h9E3779B1) ^ 32'h05A5A5A5);
    endfunction

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Core modules: a word changes only once a full inhibit phase
    // has completed, i.e. when the owner is acknowledged.
    initial begin
        for (int i = 0; i < 2**AW; i++) begin
            mem_a[i] <= init_word(i);
            mem_b[i] <= init_word(i);
        end
        forever begin
            @(posedge CLK);
            if (INHBS) begin
                pend_word <= ~MEM_INH;
                pend_addr <= MEM_ADDR;
                pend_a    <= MAO;
                pend_b    <= MBO;
            end
            if (CPU_ACK || DMA_ACK) begin
                if (pend_a) mem_a[pend_addr] <= pend_word;
                if (pend_b) mem_b[pend_addr] <= pend_word;
            end
        end
    end

    // Word-level view: what each module holds after the access.
    function automatic exp_t model(input bit we, input logic [AW-1:0] a,
                                   input logic [DW-1:0] w);
        exp_t e;
        logic [DW-1:0] va;
        logic [DW-1:0] vb;
        bit sa;
        bit sb;
        va = ref_a[a];
        vb = ref_b[a];
        sa = DUPLEX || !MODSEL;
        sb = DUPLEX || MODSEL;
        e.rdata = sa ? va : vb;
        e.mis = DUPLEX && (va != vb);
        if (we) begin
            if (sa) ref_a[a] = w;
            if (sb) ref_b[a] = w;
        end else if (DUPLEX) begin
            ref_b[a] = va;
        end
        return e;
    endfunction

    task automatic issue(input bit d, input bit we, input logic [AW-1:0] a,
                         input logic [DW-1:0] w, input bit early);
        exp_t e;
        int n;
        bit got;
        e = model(we, a, w);
        if (d) begin
            dma_q.push_back(e);
            DMA_WE = we; DMA_ADDR = a; DMA_WDATA = w; DMA_REQ = 1'b1;
        end else begin
            cpu_q.push_back(e);
            CPU_WE = we; CPU_ADDR = a; CPU_WDATA = w; CPU_REQ = 1'b1;
        end
        n = 0;
        got = 1'b0;
        while (!got && n < 400) begin
            @(negedge CLK);
            n++;
            if (early && d && RD) DMA_REQ = 1'b0;
            got = d ? DMA_ACK : CPU_ACK;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: requester %0d got no ACK, required one", d);
        end
        @(posedge CLK);
        #1;
        if (d) DMA_REQ = 1'b0;
        else CPU_REQ = 1'b0;
    endtask

    // Monitor: phase lengths, select lines, latency and scoreboard.
    int   cyc = 0;
    int   busy_start = 0;
    int   rd_run = 0;
    int   wr_run = 0;
    int   sy_run = 0;
    logic busy_d = 1'b0;

    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            cyc++;
            if (!RSTN) begin
                rd_run = 0; wr_run = 0; sy_run = 0; busy_d = 1'b0;
            end else begin
                if (BUSY && !busy_d) busy_start = cyc;
                busy_d = BUSY;
                if (RD) rd_run++;
                else if (rd_run != 0) begin chk("rd_len", rd_run, 3); rd_run = 0; end
                if (INHBS) wr_run++;
                else if (wr_run != 0) begin chk("inhbs_len", wr_run, 3); wr_run = 0; end
                if (SYNC) sy_run++;
                else if (sy_run != 0) begin chk("sync_len", sy_run, 1); sy_run = 0; end
                if (!INHBS) chk("inh_idle", MEM_INH, 0);
                chk("mao", MAO, BUSY && (DUPLEX || !MODSEL));
                chk("mbo", MBO, BUSY && (DUPLEX || MODSEL));
                if (CPU_ACK) begin
                    chk("cpu_latency", cyc - busy_start, 8);
                    ack_log.push_back(1'b0);
                    if (cpu_q.size() == 0) begin
                        chk("cpu_ack_unexpected", CPU_ACK, 0);
                    end else begin
                        e = cpu_q.pop_front();
                        chk("cpu_rdata", CPU_RDATA, e.rdata);
                        chk("cpu_miscmp", MISCMP, e.mis);
                    end
                end
                if (DMA_ACK) begin
                    chk("dma_latency", cyc - busy_start, 8);
                    ack_log.push_back(1'b1);
                    if (dma_q.size() == 0) begin
                        chk("dma_ack_unexpected", DMA_ACK, 0);
                    end else begin
                        e = dma_q.pop_front();
                        chk("dma_rdata", DMA_RDATA, e.rdata);
                        chk("dma_miscmp", MISCMP, e.mis);
                    end
                end
            end
        end
    end

    task automatic wait_inhbs(input string name);
        int n;
        n = 0;
        while (!INHBS && n < 100) begin @(negedge CLK); n++; end
        chk(name, INHBS, 1);
    endtask

    task automatic check_order(input string name, input int len,
                               input logic [7:0] exp);
        logic [7:0] got;
        got = '0;
        chk({name, "_count"}, ack_log.size(), len);
        for (int i = 0; i < ack_log.size() && i < 8; i++)
            got = {got[6:0], ack_log[i]};
        chk(name, got, exp);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 2**AW; i++) begin
            ref_a[i] = init_word(i);
            ref_b[i] = init_word(i);
        end
        repeat (3) @(negedge CLK);
        chk("reset_state",
            {BUSY, MAO, MBO, RD, SYNC, INHBS, CPU_ACK, DMA_ACK, MISCMP,
             MEM_ADDR, MEM_INH, CPU_RDATA, DMA_RDATA}, '0);
        RSTN = 1'b1;
        @(negedge CLK);

        // Simplex read from module A
        DUPLEX = 1'b0; MODSEL = 1'b0;
        fork
            issue(1'b0, 1'b0, 13'h0123, '0, 1'b0);
            begin
                wait_inhbs("t1_reach_write");
                chk("t1_inh", MEM_INH, 28'hF543210);
                chk("t1_sel", {MAO, MBO}, 2'b10);
            end
        join

        // Duplex DMA write at the top address
        DUPLEX = 1'b1;
        fork
            issue(1'b1, 1'b1, 13'h1FFF, 28'h5555555, 1'b0);
            begin
                wait_inhbs("t2_reach_write");
                chk("t2_inh", MEM_INH, 28'hAAAAAAA);
                chk("t2_sel", {MAO, MBO}, 2'b11);
            end
        join

        // Diverge the modules, then duplex reads with and without mismatch
        DUPLEX = 1'b0; MODSEL = 1'b0;
        issue(1'b0, 1'b1, 13'h0040, 28'h0000001, 1'b0);
        MODSEL = 1'b1;
        issue(1'b0, 1'b1, 13'h0040, 28'h0000000, 1'b0);
        DUPLEX = 1'b1;
        issue(1'b0, 1'b0, 13'h0040, '0, 1'b0);
        issue(1'b0, 1'b0, 13'h0040, '0, 1'b0);

        // Randomized traffic; CPU and DMA use disjoint address halves
        for (int s = 0; s < 8; s++) begin
            DUPLEX = 1'($urandom_range(0, 1));
            MODSEL = 1'($urandom_range(0, 1));
            fork
                for (int i = 0; i < 6; i++) begin
                    repeat ($urandom_range(0, 2)) @(negedge CLK);
                    issue(1'b0, 1'($urandom_range(0, 1)),
                          {1'b0, 8'h00, 4'($urandom_range(0, 15))},
                          28'($urandom), 1'b0);
                end
                for (int j = 0; j < 6; j++) begin
                    repeat ($urandom_range(0, 2)) @(negedge CLK);
                    issue(1'b1, 1'($urandom_range(0, 1)),
                          {1'b1, 8'h00, 4'($urandom_range(0, 15))},
                          28'($urandom), 1'b0);
                end
            join
        end

        // Reset during the inhibit phase aborts; the held request reruns
        DUPLEX = 1'b0; MODSEL = 1'b1;
        fork
            issue(1'b0, 1'b1, 13'h0456, 28'h1234567, 1'b0);
            begin
                wait_inhbs("t5_reach_write");
                #2 RSTN = 1'b0;
                #1;
                chk("t5_abort",
                    {BUSY, MAO, MBO, RD, SYNC, INHBS, CPU_ACK, DMA_ACK, MISCMP,
                     MEM_ADDR, MEM_INH, CPU_RDATA, DMA_RDATA}, '0);
                repeat (3) @(negedge CLK);
                #2 RSTN = 1'b1;
            end
        join

        // Both requesters held: DMA burst, then the CPU gets a turn
        DUPLEX = 1'b1;
        ack_log.delete();
        fork
            repeat (2) issue(1'b0, 1'b0, {1'b0, 8'h01, 4'($urandom_range(0, 15))}, '0, 1'b0);
            repeat (6) issue(1'b1, 1'b0, {1'b1, 8'h01, 4'($urandom_range(0, 15))}, '0, 1'b0);
        join
        check_order("t4_order", 8, 8'b1111_0110);

        // DMA drops its request mid-read; CPU waiting behind it
        ack_log.delete();
        fork
            issue(1'b1, 1'b1, 13'h1077, 28'h0F0F0F0, 1'b1);
            begin
                repeat (2) @(negedge CLK);
                issue(1'b0, 1'b0, 13'h0077, '0, 1'b0);
            end
        join
        check_order("t6_order", 2, 8'b0000_0010);

        repeat (4) @(negedge CLK);
        chk("cpu_queue_drained", cpu_q.size(), 0);
        chk("dma_queue_drained", dma_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
